// File: rtl/regfile_sb.sv
// Register file with two async read ports, one sync write port and a busy scoreboard.
// Optional same-cycle write-through on reads: define REGFILE_BYPASS_EN.
module regfile_sb #(
    parameter int unsigned N         = 32,
    parameter int unsigned DEPTH     = 32,
    parameter int unsigned AW        = 5,
    parameter int unsigned RESET_VAL = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] readreg1,
    input  logic [AW-1:0] readreg2,
    output logic [N-1:0]  regdata1,
    output logic [N-1:0]  regdata2,
    input  logic [AW-1:0] writereg,
    input  logic [N-1:0]  data,
    input  logic          rw,
    input  logic          issue_en,
    input  logic [AW-1:0] issue_reg,
    output logic          busy1,
    output logic          busy2,
    output logic          hazard,
    output logic [AW:0]   busy_count
);

    localparam int unsigned CW = AW + 1;

    logic [N-1:0]     r_regs [DEPTH];
    logic [DEPTH-1:0] r_busy;
    logic [CW-1:0]    r_busy_count;

    logic             w_wr;
    logic             w_set;
    logic             w_clr;
    logic             w_inc;
    logic             w_dec;
    logic [DEPTH-1:0] w_busy_next;

    assign w_wr  = rw && (writereg != '0);
    assign w_set = issue_en && (issue_reg != '0);
    // A new producer for the same register supersedes the completing one
    assign w_clr = w_wr && !(w_set && (issue_reg == writereg));
    assign w_inc = w_set && !r_busy[issue_reg];
    assign w_dec = w_clr && r_busy[writereg];

    always_comb begin
        w_busy_next = r_busy;
        if (w_clr) w_busy_next[writereg] = 1'b0;
        if (w_set) w_busy_next[issue_reg] = 1'b1;
        w_busy_next[0] = 1'b0;
    end

    // Register array, scoreboard and busy counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_regs[0] <= '0;
            for (int i = 1; i < int'(DEPTH); i++) r_regs[i] <= N'(RESET_VAL);
            r_busy       <= '0;
            r_busy_count <= '0;
        end else begin
            if (w_wr) r_regs[writereg] <= data;
            r_busy <= w_busy_next;
            case ({w_inc, w_dec})
                2'b10:   r_busy_count <= r_busy_count + CW'(1);
                2'b01:   r_busy_count <= r_busy_count - CW'(1);
                default: r_busy_count <= r_busy_count;
            endcase
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic w_byp1;
    logic w_byp2;

    assign w_byp1   = w_wr && (readreg1 == writereg);
    assign w_byp2   = w_wr && (readreg2 == writereg);
    assign regdata1 = (readreg1 == '0) ? '0 : (w_byp1 ? data : r_regs[readreg1]);
    assign regdata2 = (readreg2 == '0) ? '0 : (w_byp2 ? data : r_regs[readreg2]);
    assign busy1    = r_busy[readreg1] && !w_byp1;
    assign busy2    = r_busy[readreg2] && !w_byp2;
`else
    assign regdata1 = (readreg1 == '0) ? '0 : r_regs[readreg1];
    assign regdata2 = (readreg2 == '0) ? '0 : r_regs[readreg2];
    assign busy1    = r_busy[readreg1];
    assign busy2    = r_busy[readreg2];
`endif

    assign hazard     = busy1 || busy2;
    assign busy_count = r_busy_count;

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed vector table, bypass sequence, random vs. model.
module tb_regfile_sb;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  readreg1 = '0, readreg2 = '0, writereg = '0, issue_reg = '0;
    logic [31:0] regdata1, regdata2, data = '0;
    logic        rw = 1'b0, issue_en = 1'b0;
    logic        busy1, busy2, hazard;
    logic [5:0]  busy_count;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_sb dut (
        .clk(clk), .rst(rst),
        .readreg1(readreg1), .readreg2(readreg2),
        .regdata1(regdata1), .regdata2(regdata2),
        .writereg(writereg), .data(data), .rw(rw),
        .issue_en(issue_en), .issue_reg(issue_reg),
        .busy1(busy1), .busy2(busy2), .hazard(hazard),
        .busy_count(busy_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          rw;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        bit          iss;
        logic [4:0]  ireg;
        logic [4:0]  rr1;
        logic [4:0]  rr2;
        logic [31:0] e1;
        logic [31:0] e2;
        bit          eb1;
        bit          eb2;
        logic [5:0]  ecnt;
    } step_t;

    step_t tbl[16];

    // Behavioural model state
    logic [31:0] m_r [32];
    bit          m_busy [32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] e1, input logic [31:0] e2,
                           input bit eb1, input bit eb2, input logic [5:0] ecnt);
        chk({tag, ".regdata1"}, regdata1, e1);
        chk({tag, ".regdata2"}, regdata2, e2);
        chk({tag, ".busy1"}, 32'(busy1), 32'(eb1));
        chk({tag, ".busy2"}, 32'(busy2), 32'(eb2));
        chk({tag, ".hazard"}, 32'(hazard), 32'(eb1 | eb2));
        chk({tag, ".busy_count"}, 32'(busy_count), 32'(ecnt));
    endtask

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a, input bit w, input logic [4:0] wa,
                                           input logic [31:0] wd);
        if (a == 0) return 32'h0;
        if (BYP && w && wa != 0 && a == wa) return wd;
        return m_r[a];
    endfunction

    function automatic bit m_isbusy(input logic [4:0] a, input bit w, input logic [4:0] wa);
        if (a == 0) return 1'b0;
        if (BYP && w && wa != 0 && a == wa) return 1'b0;
        return m_busy[a];
    endfunction

    initial begin
        //          rst rw  wreg   wdata         iss ireg   rr1    rr2    e1            e2            b1 b2 cnt
        tbl[0]  = '{1, 0, 5'd0,  32'h0,        0, 5'd0,  5'd0,  5'd5,  32'h0,        32'h1,        0, 0, 6'd0};
        tbl[1]  = '{0, 0, 5'd0,  32'h0,        0, 5'd0,  5'd31, 5'd0,  32'h1,        32'h0,        0, 0, 6'd0};
        tbl[2]  = '{0, 1, 5'd7,  32'hDEADBEEF, 0, 5'd0,  5'd7,  5'd0,  32'hDEADBEEF, 32'h0,        0, 0, 6'd0};
        tbl[3]  = '{0, 1, 5'd0,  32'h12345678, 0, 5'd0,  5'd0,  5'd7,  32'h0,        32'hDEADBEEF, 0, 0, 6'd0};
        tbl[4]  = '{0, 0, 5'd0,  32'h0,        1, 5'd3,  5'd3,  5'd7,  32'h1,        32'hDEADBEEF, 1, 0, 6'd1};
        tbl[5]  = '{0, 1, 5'd3,  32'hA5,       0, 5'd0,  5'd3,  5'd7,  32'hA5,       32'hDEADBEEF, 0, 0, 6'd0};
        tbl[6]  = '{0, 0, 5'd0,  32'h0,        1, 5'd4,  5'd4,  5'd9,  32'h1,        32'h1,        1, 0, 6'd1};
        tbl[7]  = '{0, 1, 5'd4,  32'h44,       1, 5'd4,  5'd4,  5'd9,  32'h44,       32'h1,        1, 0, 6'd1};
        tbl[8]  = '{0, 1, 5'd4,  32'h99,       1, 5'd9,  5'd4,  5'd9,  32'h99,       32'h1,        0, 1, 6'd1};
        tbl[9]  = '{0, 1, 5'd9,  32'h9,        1, 5'd0,  5'd4,  5'd9,  32'h99,       32'h9,        0, 0, 6'd0};
        tbl[10] = '{0, 0, 5'd0,  32'h0,        1, 5'd2,  5'd2,  5'd6,  32'h1,        32'h1,        1, 0, 6'd1};
        tbl[11] = '{0, 1, 5'd2,  32'h77,       1, 5'd6,  5'd2,  5'd6,  32'h77,       32'h1,        0, 1, 6'd1};
        tbl[12] = '{0, 0, 5'd0,  32'h0,        1, 5'd7,  5'd2,  5'd6,  32'h77,       32'h1,        0, 1, 6'd2};
        tbl[13] = '{0, 0, 5'd0,  32'h0,        1, 5'd8,  5'd8,  5'd7,  32'h1,        32'hDEADBEEF, 1, 1, 6'd3};
        tbl[14] = '{1, 1, 5'd6,  32'h66,       1, 5'd8,  5'd8,  5'd2,  32'h1,        32'h1,        0, 0, 6'd0};
        tbl[15] = '{0, 0, 5'd0,  32'h0,        0, 5'd0,  5'd6,  5'd7,  32'h1,        32'h1,        0, 0, 6'd0};

        // Directed table: apply one edge, then check with rw/issue idle
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            rst = tbl[i].rst; rw = tbl[i].rw; writereg = tbl[i].wreg; data = tbl[i].wdata;
            issue_en = tbl[i].iss; issue_reg = tbl[i].ireg;
            readreg1 = tbl[i].rr1; readreg2 = tbl[i].rr2;
            @(posedge clk);
            #1 rst = 1'b0; rw = 1'b0; issue_en = 1'b0;
            #1 chk_all($sformatf("vec%0d", i), tbl[i].e1, tbl[i].e2, tbl[i].eb1, tbl[i].eb2, tbl[i].ecnt);
        end

        // Same-cycle writeback to a busy register being read
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0; issue_en = 1'b1; issue_reg = 5'd10;
        @(negedge clk); issue_en = 1'b0;
        rw = 1'b1; writereg = 5'd10; data = 32'h55; readreg1 = 5'd0; readreg2 = 5'd10;
        #1;
        chk("byp.regdata2", regdata2, BYP ? 32'h55 : 32'h1);
        chk("byp.busy2", 32'(busy2), BYP ? 32'h0 : 32'h1);
        chk("byp.hazard", 32'(hazard), BYP ? 32'h0 : 32'h1);
        chk("byp.busy_count", 32'(busy_count), 32'h1);
        @(posedge clk);
        #1 rw = 1'b0;
        #1 chk_all("byp.after", 32'h0, 32'h55, 0, 0, 6'd0);

        // Randomized run against the model
        @(negedge clk); rst = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 32; i++) begin
            m_r[i] = (i == 0) ? 32'h0 : 32'h1;
            m_busy[i] = 1'b0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            rst       = ($urandom_range(0, 99) == 0);
            rw        = $urandom_range(0, 1) == 1;
            issue_en  = $urandom_range(0, 2) != 0;
            writereg  = 5'($urandom_range(0, 11));
            issue_reg = 5'($urandom_range(0, 11));
            readreg1  = ($urandom_range(0, 2) == 0) ? writereg : 5'($urandom_range(0, 31));
            readreg2  = 5'($urandom_range(0, 11));
            data      = $urandom;
            #1;
            chk("rnd.regdata1", regdata1, m_read(readreg1, rw, writereg, data));
            chk("rnd.regdata2", regdata2, m_read(readreg2, rw, writereg, data));
            chk("rnd.busy1", 32'(busy1), 32'(m_isbusy(readreg1, rw, writereg)));
            chk("rnd.busy2", 32'(busy2), 32'(m_isbusy(readreg2, rw, writereg)));
            chk("rnd.hazard", 32'(hazard),
                32'(m_isbusy(readreg1, rw, writereg) | m_isbusy(readreg2, rw, writereg)));
            chk("rnd.busy_count", 32'(busy_count), 32'(m_count()));
            @(posedge clk);
            if (rst) begin
                for (int i = 0; i < 32; i++) begin
                    m_r[i] = (i == 0) ? 32'h0 : 32'h1;
                    m_busy[i] = 1'b0;
                end
            end else begin
                if (rw && writereg != 0) begin
                    m_r[writereg] = data;
                    m_busy[writereg] = 1'b0;
                end
                if (issue_en && issue_reg != 0) m_busy[issue_reg] = 1'b1;
            end
        end
        @(negedge clk); rst = 1'b0; rw = 1'b0; issue_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised general-purpose register file for the pipelined RISC core.
- Two asynchronous read ports and one synchronous write port.
- Register 0 is hardwired to zero.
- Integrated per-register busy scoreboard for RAW hazard detection between decode and writeback, with a registered busy-count.
- Sits between the decode stage (reads, issue) and the writeback stage (write, busy clear).

Parameters:
N, 32, data width of each register.
DEPTH, 32, number of registers; power of two, minimum 2.
AW, 5, register address width; must equal log2(DEPTH).
RESET_VAL, 1, value loaded into registers 1..DEPTH-1 on reset (N-bit, zero-extended).

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
readreg1  in  AW  read address, port 1
readreg2  in  AW  read address, port 2
regdata1  out  N  read data, port 1 (combinational)
regdata2  out  N  read data, port 2 (combinational)
writereg  in  AW  write address (writeback stage)
data  in  N  write data
rw  in  1  write enable; also clears busy[writereg]
issue_en  in  1  decode issued an instruction with a destination register
issue_reg  in  AW  destination register of issued instruction
busy1  out  1  busy[readreg1] after bypass masking
busy2  out  1  busy[readreg2] after bypass masking
hazard  out  1  busy1 | busy2
busy_count  out  AW+1  registered number of busy registers

Behaviour:
Reset:
- On a rising edge with rst=1: r[0]=0, r[1..DEPTH-1]=RESET_VAL, all busy bits=0, busy_count=0.
- rst overrides rw and issue_en in the same cycle.
- After reset, regdata1/2 reflect RESET_VAL, or 0 for address 0; busy1, busy2 and hazard are 0.

Write:
- At a rising edge with rw=1 and writereg!=0: r[writereg] <= data. One-cycle write latency.
- Writes to address 0 are discarded; r[0] always reads 0.

Read:
- regdata = r[readreg], purely combinational, zero wait.
- Address 0 always returns 0.
- Same-cycle read/write collision behaviour is set by REGFILE_BYPASS_EN.

Scoreboard:
- busy[] is a DEPTH-bit register; busy[0] is constantly 0.
- At a rising edge, issue_en=1 with issue_reg!=0 sets busy[issue_reg].
- At a rising edge, rw=1 with writereg!=0 clears busy[writereg].
- Set and clear of the same register in the same cycle: set wins (a new producer supersedes the completing one); busy stays 1.
- Set and clear of different registers apply independently.
- Setting an already-busy register changes nothing. Clearing a non-busy register changes nothing.

busy_count:
- Updated each edge by +1 if the set targets a not-yet-busy register, and -1 if the clear targets a busy register that is not also being set.
- Net 0 when both apply.
- Range 0..DEPTH-1; never wraps.

Hazard:
- busy1/busy2 are combinational from the busy register and current addresses.
- Address 0 is never busy.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined: when rw=1, writereg!=0 and readregX==writereg, regdataX = data (write-through in the same cycle) and busyX is forced 0 for that port. This lets decode proceed in the writeback cycle.
- Not defined: regdataX returns the old stored value during a colliding write; busyX follows the stored busy bit, so hazard stays asserted until the cycle after writeback.
- Scoreboard state and busy_count are identical in both builds.

Test Plan:
1. Reset and read: rst=1 for one edge, then read addresses 0, 5, 31 -> regdata 0, 1, 1; busy_count=0; hazard=0.
2. Write and r0 protection: write 0xDEADBEEF to r7, then write 0x12345678 to r0 -> r7 reads 0xDEADBEEF next cycle; r0 reads 0.
3. Scoreboard set/clear: issue r3 (busy_count=1, busy1=1 with readreg1=3, hazard=1); next cycle rw to r3 with 0xA5 -> busy_count=0, busy1=0 after the edge, r3=0xA5.
4. Simultaneous events: with r4 busy, same cycle issue r4 and rw r4 -> busy[4] stays 1, count unchanged. Same cycle issue r9 and rw r4 -> busy_count unchanged; busy[9]=1, busy[4]=0.
5. Bypass: r10 busy and holds 0x1; same cycle rw r10 with 0x55 and readreg2=10. With REGFILE_BYPASS_EN: regdata2=0x55, busy2=0. Without: regdata2=0x1, busy2=1.
6. Reset mid-operation: 3 registers busy, r2=0x77; assert rst together with rw r6 and issue r8 -> after the edge all regs are RESET_VAL, busy_count=0, busy[8]=0.
